bf_pipe_unified: RTL and testbench

Parametrised successor butterfly for the NTT/MSM datapath. It is a single fully pipelined unit that executes a Cooley-Tukey NTT butterfly, a Gentleman-Sande INTT butterfly with built-in halving, or raw modular add/sub/mul, selected per transaction. Unlike the previous fixed-width, free-running butterfly, it has generic width, modulus and multiplier latency. It also has valid/ready flow control with global stall, per-item mode tagging, in-flight tracking and a sticky error flag. It sits between the NTT address/coefficient scheduler and the coefficient write-back buffer.

---
 rtl/bf_pipe_unified.sv | 198 +++++++++++++++++++
 tb/tb_bf_pipe_unified.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bf_pipe_unified.sv
// Pipelined modular butterfly: CT NTT, GS INTT with halving, or raw add/sub/mul, tagged per item.
// Define BF_PIPE_SKID_EN to add a 2-entry output skid FIFO that decouples in_ready from out_ready.
module bf_pipe_unified #(
  parameter int              DATA_W  = 64,
  parameter logic [DATA_W-1:0] M      = 64'hffff_ffff_0000_0001,
  parameter logic [DATA_W-1:0] M_HALF = 64'h7fff_ffff_8000_0001,
  parameter int              MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_mode,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_c,
  output logic              busy,
  output logic              err_mode
);
  localparam int PL = MUL_LAT + 2;
`ifdef BF_PIPE_SKID_EN
  localparam int L = PL + 1;
`else
  localparam int L = PL;
`endif
  localparam int CW = $clog2(L + 2);
  localparam int EW = 2 + 3 * DATA_W;
  localparam logic [2*DATA_W-1:0] MX = {{DATA_W{1'b0}}, M};

  function automatic logic [DATA_W-1:0] add_m(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, M}) s = s - {1'b0, M};
    return s[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] sub_m(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [DATA_W:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + {1'b0, M};
    return s[DATA_W-1:0];
  endfunction

  // Odd x: (x+M)/2 computed as (x>>1)+(M+1)/2 to stay within DATA_W bits.
  function automatic logic [DATA_W-1:0] half_m(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] h;
    h = {1'b0, x[DATA_W-1:1]};
    return x[0] ? h + M_HALF : h;
  endfunction

  logic              w_acc, w_xfer, w_en;
  logic [PL:1]       vld_pipe;
  logic [1:0]        r_md [1:PL-1];
  logic [DATA_W-1:0] r_a  [1:PL-1];
  logic [DATA_W-1:0] r_s  [1:PL-1];
  logic [DATA_W-1:0] r_d  [1:PL-1];
  logic [DATA_W-1:0] r_mx, r_my;
  logic [2*DATA_W-1:0] r_mp [1:MUL_LAT];
  logic [DATA_W-1:0] w_s, w_d, w_my, w_t;
  logic [1:0]        r_fmode;
  logic [DATA_W-1:0] r_fa, r_fb, r_fc, w_fa, w_fb, w_fc;
  logic [2*DATA_W-1:0] w_prod;
  logic [CW-1:0]     r_cnt;
  logic              r_err;

  assign w_acc  = in_valid && in_ready;
  assign w_s    = add_m(in_a, in_b);
  assign w_d    = sub_m(in_a, in_b);
  assign w_my   = (in_mode == 2'd0) ? in_b : (in_mode == 2'd1) ? w_d : in_a;
  assign w_prod = {{DATA_W{1'b0}}, r_mx} * {{DATA_W{1'b0}}, r_my};
  assign w_t    = r_mp[MUL_LAT][DATA_W-1:0];

  // Data path carries no reset; validity lives only in vld_pipe.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_md[1] <= in_mode;
      r_a[1]  <= in_a;
      r_s[1]  <= w_s;
      r_d[1]  <= w_d;
      r_mx    <= in_w;
      r_my    <= w_my;
      for (int k = 2; k <= PL - 1; k++) begin
        r_md[k] <= r_md[k-1];
        r_a[k]  <= r_a[k-1];
        r_s[k]  <= r_s[k-1];
        r_d[k]  <= r_d[k-1];
      end
      r_mp[1] <= (MUL_LAT == 1) ? w_prod % MX : w_prod;
      for (int k = 2; k <= MUL_LAT; k++)
        r_mp[k] <= (k == MUL_LAT) ? r_mp[k-1] % MX : r_mp[k-1];
    end
  end

  always_comb begin
    w_fa = '0;
    w_fb = '0;
    w_fc = '0;
    case (r_md[PL-1])
      2'd0: begin w_fa = add_m(r_a[PL-1], w_t); w_fb = sub_m(r_a[PL-1], w_t); end
      2'd1: begin w_fa = half_m(r_s[PL-1]);     w_fb = half_m(w_t);           end
      2'd2: begin w_fa = r_s[PL-1]; w_fb = r_d[PL-1]; w_fc = w_t;              end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      r_fmode  <= '0;
      r_fa     <= '0;
      r_fb     <= '0;
      r_fc     <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_acc && in_mode == 2'd3) r_err <= 1'b1;
      case ({w_acc, w_xfer})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
      if (w_en) begin
        vld_pipe <= {vld_pipe[PL-1:1], w_acc};
        r_fmode  <= r_md[PL-1];
        r_fa     <= w_fa;
        r_fb     <= w_fb;
        r_fc     <= w_fc;
      end
    end
  end

  assign busy     = (r_cnt != '0);
  assign err_mode = r_err;

`ifdef BF_PIPE_SKID_EN
  logic [EW-1:0] r_q0, r_q1;
  logic [1:0]    r_occ;
  logic          w_full, w_empty, w_push, w_pop;

  assign w_full    = (r_occ == 2'd2);
  assign w_empty   = (r_occ == 2'd0);
  assign w_pop     = !w_empty && out_ready;
  // Last stage blocks only when the FIFO is full and nothing drains this cycle.
  assign w_en      = !(vld_pipe[PL] && w_full) || w_pop;
  assign w_push    = vld_pipe[PL] && w_en;
  assign in_ready  = !w_full && !(vld_pipe[PL] && w_full);
  assign w_xfer    = w_pop;
  assign out_valid = !w_empty;
  assign {out_mode, out_a, out_b, out_c} = r_q0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_occ <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (w_empty) r_q0 <= {r_fmode, r_fa, r_fb, r_fc};
          else         r_q1 <= {r_fmode, r_fa, r_fb, r_fc};
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_occ <= r_occ - 2'd1;
        end
        2'b11: begin
          if (w_full) begin
            r_q0 <= r_q1;
            r_q1 <= {r_fmode, r_fa, r_fb, r_fc};
          end else begin
            r_q0 <= {r_fmode, r_fa, r_fb, r_fc};
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic w_stall;
  assign w_stall   = vld_pipe[PL] && !out_ready;
  assign w_en      = !w_stall;
  assign in_ready  = !w_stall;
  assign w_xfer    = vld_pipe[PL] && out_ready;
  assign out_valid = vld_pipe[PL];
  assign out_mode  = r_fmode;
  assign out_a     = r_fa;
  assign out_b     = r_fb;
  assign out_c     = r_fc;
`endif

endmodule

// File: tb/tb_bf_pipe_unified.sv
// Self-checking bench for bf_pipe_unified (DATA_W=8, M=97, MUL_LAT=4) with an arithmetic reference model.
module tb_bf_pipe_unified;
  localparam int MUL_LAT = 4;
`ifdef BF_PIPE_SKID_EN
  localparam int L = MUL_LAT + 3;
`else
  localparam int L = MUL_LAT + 2;
`endif

  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [1:0] in_mode = 0;
  logic [7:0] in_a = 0, in_b = 0, in_w = 0;
  logic       in_ready, out_valid, busy, err_mode;
  logic [1:0] out_mode;
  logic [7:0] out_a, out_b, out_c;

  bf_pipe_unified #(.DATA_W(8), .M(8'd97), .M_HALF(8'd49), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_a(out_a), .out_b(out_b), .out_c(out_c), .busy(busy),
    .err_mode(err_mode));

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] m; logic [7:0] a, b, c; } res_t;
  res_t exp_q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, rx = 0, st = 0;
  bit   burst = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int hlf(int x);
    return (x % 2 == 0) ? x / 2 : (x + 97) / 2;
  endfunction

  function automatic res_t model(int m, int a, int b, int w);
    res_t r;
    int t, s, d;
    r = '0;
    r.m = 2'(m);
    s = (a + b) % 97;
    d = (a - b + 97) % 97;
    case (m)
      0: begin t = (w * b) % 97; r.a = 8'((a + t) % 97); r.b = 8'((a - t + 97) % 97); end
      1: begin r.a = 8'(hlf(s)); r.b = 8'(hlf((d * w) % 97)); end
      2: begin r.a = 8'(s); r.b = 8'(d); r.c = 8'((a * w) % 97); end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: push the model result on accept, compare in order on output transfer.
  always @(negedge clk) begin
    res_t got, e;
    if (!rst_n) exp_q.delete();
    else begin
`ifndef BF_PIPE_SKID_EN
      n_chk++;
      assert (in_ready === !(out_valid && !out_ready)) else begin
        n_fail++;
        $error("FAIL in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
      end
`endif
      if (out_valid && out_ready) begin
        rx++;
        n_chk++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL spurious_out: got out_valid with %0d pending expected none", exp_q.size());
        end
        if (exp_q.size() > 0) begin
          got = {out_mode, out_a, out_b, out_c};
          e = exp_q.pop_front();
          n_chk++;
          assert (got === e) else begin
            n_fail++;
            $error("FAIL result: got %h expected %h", got, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_a, in_b, in_w));
    end
  end

  task automatic set_or();
    out_ready = !(burst && (cyc - st) >= 8 && (cyc - st) <= 12);
  endtask

  task automatic send(int m, int a, int b, int w);
    bit acc;
    acc = 0;
    in_valid = 1; in_mode = 2'(m); in_a = 8'(a); in_b = 8'(b); in_w = 8'(w);
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      set_or();
    end
    in_valid = 0;
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  // Called right after the accept edge; returns cycles from accept cycle to out_valid.
  task automatic wait_out(output int lat);
    bit found;
    found = 0;
    lat = 1;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge clk); #1;
      if (out_valid) found = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    if (!found) lat = -1;
  endtask

  initial begin
    int lat, rx0;
    bit seen;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_mode, 0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk); #1;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send(0, 10, 20, 3); wait_out(lat);
    chk("ct_lat", lat, L); chk("ct_a", out_a, 70); chk("ct_b", out_b, 47);
    chk("ct_c", out_c, 0); chk("ct_mode", out_mode, 0);
    @(posedge clk); #1;

    send(1, 10, 20, 3); wait_out(lat);
    chk("gs_lat", lat, L); chk("gs_a", out_a, 15); chk("gs_b", out_b, 82); chk("gs_mode", out_mode, 1);
    @(posedge clk); #1;

    send(2, 50, 60, 2); wait_out(lat);
    chk("raw_a", out_a, 13); chk("raw_b", out_b, 87); chk("raw_c", out_c, 3); chk("raw_mode", out_mode, 2);
    @(posedge clk); #1;

    rx0 = rx; burst = 1; st = cyc;
    for (int i = 0; i < 20; i++)
      send($urandom_range(0, 2), $urandom_range(0, 96), $urandom_range(0, 96), $urandom_range(0, 96));
    burst = 0; out_ready = 1;
    seen = 0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && out_valid && out_ready) seen = 1;
    end
    chk("burst_drain", seen, 1);
    chk("busy_last", busy, 1);
    @(posedge clk); @(negedge clk); #1;
    chk("busy_after", busy, 0);
    chk("burst_count", rx - rx0, 20);
    @(posedge clk); #1;

    chk("err_before", err_mode, 0);
    send(3, 5, 6, 7);
    @(negedge clk); #1;
    chk("err_set", err_mode, 1);
    @(posedge clk); #1;
    send(0, 10, 20, 3);
    wait_out(lat);
    chk("m3_a", out_a, 0); chk("m3_b", out_b, 0); chk("m3_c", out_c, 0); chk("m3_mode", out_mode, 3);
    @(posedge clk); #1;
    wait_out(lat);
    chk("m3_next_a", out_a, 70); chk("m3_next_b", out_b, 47); chk("err_sticky", err_mode, 1);
    @(posedge clk); #1;

    send(2, 1, 2, 3); send(0, 4, 5, 6); send(1, 7, 8, 9);
    rst_n = 0;
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk); #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_mode, 0);
    seen = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("mid_rst_no_out", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
